miner_array: RTL

MINER_ARRAY -- requirements
Module: miner_array

---
 rtl/miner_array_pkg.sv | 22 ++
 rtl/hit_fifo.sv | 51 +++++
 rtl/odo_keccak.sv | 53 +++++
 rtl/miner_array.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/miner_array_pkg.sv
// Shared definitions for the miner array.
//   state_t      : job control states (idle / issuing nonce groups / draining lanes)
//   HEADER_W     : block header width without the nonce
//   NONCE_W      : nonce width
//   HASH_CNT_W   : width of the per-job completed-hash counter
//   TARGET_W     : width of the difficulty target and of a hash
//   LANE_IN_W    : width of one lane input word {nonce, header}
package miner_array_pkg;

  localparam int HEADER_W   = 608;
  localparam int NONCE_W    = 32;
  localparam int HASH_CNT_W = 48;
  localparam int TARGET_W   = 256;
  localparam int LANE_IN_W  = NONCE_W + HEADER_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUING = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

endpackage

// File: rtl/hit_fifo.sv
// First-word-fall-through FIFO for winning nonces.
//   clk, rst : clock, asynchronous active-high reset (flushes contents)
//   push/din : write request and data; ignored when full unless popping too
//   pop      : read request; ignored when empty
//   dout     : head entry, valid while empty is low
//   empty/full : occupancy flags
module hit_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/odo_keccak.sv
// Fixed-latency hashing lane. Accepts one {nonce, header} word whenever read
// is high and, LATENCY cycles later, raises valid for one cycle with out=1 when
// the hash of that word is strictly below target. The hash is a cheap fold/mix
// of the input whose top bit is always 0, so an all-ones target always hits and
// a zero target never does.
//   clk, rst : clock, asynchronous active-high reset of the valid pipeline
//   read     : accept data this cycle
//   data     : {nonce, header}
//   target   : difficulty target
//   valid    : result available this cycle
//   out      : result is below target
module odo_keccak
  import miner_array_pkg::*;
#(
  parameter int LATENCY = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 read,
  input  logic [LANE_IN_W-1:0] data,
  input  logic [TARGET_W-1:0]  target,
  output logic                 valid,
  output logic                 out
);

  logic [TARGET_W-2:0] fold;
  logic [TARGET_W-2:0] mixed;
  logic [TARGET_W-1:0] hash;
  logic                hit;
  logic [LATENCY-1:0]  vld_sr;
  logic [LATENCY-1:0]  hit_sr;

  always_comb begin
    fold  = data[254:0] ^ data[509:255] ^ {data[639:510], 125'd0};
    mixed = fold ^ {fold[127:0], fold[254:128]};
    hash  = {1'b0, mixed};
    hit   = hash < target;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_sr <= '0;
    else     vld_sr <= {vld_sr[LATENCY-2:0], read};
  end

  // Result bits travel alongside valid; they only matter where valid is set.
  always_ff @(posedge clk) begin
    hit_sr <= {hit_sr[LATENCY-2:0], hit};
  end

  assign valid = vld_sr[LATENCY-1];
  assign out   = hit_sr[LATENCY-1];

endmodule

// File: rtl/miner_array.sv
// Array of LANES hashing lanes searching a nonce range for hashes below target.
//   clk, rst           : clock, asynchronous active-high reset
//   header/target/nonce_base : job parameters, captured on start
//   start / stop       : begin a new job / stop issuing (start wins)
//   busy               : issuing or waiting for lane results
//   done               : pulse when the nonce space was exhausted and drained
//   hit_valid/hit_ready/hit_nonce : winning-nonce stream
//   overflow           : sticky, a hit was lost because the FIFO was full
//   hashes             : hashes completed in the current job
module miner_array
  import miner_array_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int THROUGHPUT = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [HEADER_W-1:0]   header,
  input  logic [TARGET_W-1:0]   target,
  input  logic [NONCE_W-1:0]    nonce_base,
  input  logic                  start,
  input  logic                  stop,
  output logic                  busy,
  output logic                  done,
  output logic                  hit_valid,
  input  logic                  hit_ready,
  output logic [NONCE_W-1:0]    hit_nonce,
  output logic                  overflow,
  output logic [HASH_CNT_W-1:0] hashes
);

  localparam int TP_W  = $clog2(THROUGHPUT) + 1;
  localparam int CNT_W = 8;

  state_t               state_reg, state_next;
  logic [HEADER_W-1:0]  header_reg;
  logic [TARGET_W-1:0]  target_reg;
  logic [NONCE_W-1:0]   issue_nonce_reg;  // lane-0 nonce of the next group to issue
  logic [NONCE_W-1:0]   ret_nonce_reg;    // lane-0 nonce of the next valid group to return
  logic [TP_W-1:0]      tp_cnt_reg;
  logic [CNT_W-1:0]     inflight_reg;
  logic [CNT_W-1:0]     discard_reg;
  logic                 exhausted_reg;

  logic                 issue;
  logic [NONCE_W:0]     issue_sum;
  logic                 wrap;
  logic                 ret;
  logic                 ret_good;
  logic [LANES-1:0]     lane_valid;
  logic [LANES-1:0]     lane_out;
  logic [LANES-1:0]     pending;
  logic [NONCE_W-1:0]   pending_nonce [LANES];
  logic [LANES-1:0]     drain_mask;
  logic [NONCE_W-1:0]   drain_nonce;
  logic                 drain_push;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 fifo_drop;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (start) begin
      state_next = ST_ISSUING;
    end else begin
      case (state_reg)
        ST_ISSUING: if (stop || (issue && wrap)) state_next = ST_DRAIN;
        ST_DRAIN:   if (inflight_reg == '0)      state_next = ST_IDLE;
        default:    state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    busy  = (state_reg != ST_IDLE);
    // No issue on a start/stop cycle: the group would belong to a job being
    // abandoned and only add to the discard bookkeeping.
    issue = (state_reg == ST_ISSUING) && (tp_cnt_reg == '0) && !start && !stop;
    done  = (state_reg == ST_DRAIN) && (inflight_reg == '0) && exhausted_reg && !start;
  end

  assign issue_sum = {1'b0, issue_nonce_reg} + (NONCE_W+1)'(LANES);
  assign wrap      = issue_sum[NONCE_W];

  // Results are only accepted while something is known to be in flight, so
  // anything a lane emits after reset or beyond the count is ignored.
  assign ret      = (&lane_valid) && (inflight_reg != '0);
  assign ret_good = ret && (discard_reg == '0) && !start;

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      header_reg      <= '0;
      target_reg      <= '0;
      issue_nonce_reg <= '0;
      ret_nonce_reg   <= '0;
      tp_cnt_reg      <= '0;
      inflight_reg    <= '0;
      discard_reg     <= '0;
      exhausted_reg   <= 1'b0;
      hashes          <= '0;
      overflow        <= 1'b0;
    end else begin
      case ({issue, ret})
        2'b10:   inflight_reg <= inflight_reg + CNT_W'(1);
        2'b01:   inflight_reg <= inflight_reg - CNT_W'(1);
        default: inflight_reg <= inflight_reg;
      endcase

      if (start) begin
        header_reg      <= header;
        target_reg      <= target;
        issue_nonce_reg <= nonce_base;
        ret_nonce_reg   <= nonce_base;
        tp_cnt_reg      <= '0;
        // Everything still in flight after this cycle's return belongs to the
        // old job; a group returning on the start cycle is dropped as well.
        discard_reg     <= inflight_reg - CNT_W'(ret);
        exhausted_reg   <= 1'b0;
        hashes          <= '0;
        overflow        <= 1'b0;
      end else begin
        if (issue) begin
          issue_nonce_reg <= issue_sum[NONCE_W-1:0];
          tp_cnt_reg      <= TP_W'(THROUGHPUT - 1);
          if (wrap) exhausted_reg <= 1'b1;
        end else if (tp_cnt_reg != '0) begin
          tp_cnt_reg <= tp_cnt_reg - TP_W'(1);
        end
        if (ret && (discard_reg != '0)) discard_reg <= discard_reg - CNT_W'(1);
        if (ret_good) begin
          hashes        <= hashes + HASH_CNT_W'(LANES);
          ret_nonce_reg <= ret_nonce_reg + NONCE_W'(LANES);
        end
        if (fifo_drop) overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- lanes
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [NONCE_W-1:0] lane_nonce;
      logic               pend_bit_reg;
      logic [NONCE_W-1:0] pend_nonce_reg;

      assign lane_nonce = issue_nonce_reg + NONCE_W'(gi);

      odo_keccak u_core (
        .clk    (clk),
        .rst    (rst),
        .read   (issue),
        .data   ({lane_nonce, header_reg}),
        .target (target_reg),
        .valid  (lane_valid[gi]),
        .out    (lane_out[gi])
      );

      // A new hit takes priority over clearing: groups return no faster than
      // one per THROUGHPUT >= LANES cycles, so the old hit has already left.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pend_bit_reg   <= 1'b0;
          pend_nonce_reg <= '0;
        end else if (ret_good && lane_out[gi]) begin
          pend_bit_reg   <= 1'b1;
          pend_nonce_reg <= ret_nonce_reg + NONCE_W'(gi);
        end else if (drain_mask[gi]) begin
          pend_bit_reg   <= 1'b0;
        end
      end

      assign pending[gi]       = pend_bit_reg;
      assign pending_nonce[gi] = pend_nonce_reg;
    end
  endgenerate

  // Lowest pending lane drains first, one per cycle.
  always_comb begin
    drain_mask  = '0;
    drain_nonce = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (pending[i]) begin
        drain_mask    = '0;
        drain_mask[i] = 1'b1;
        drain_nonce   = pending_nonce[i];
      end
    end
  end

  assign drain_push = |pending;
  // Full implies non-empty, so hit_ready alone decides whether a slot frees.
  assign fifo_drop  = drain_push && fifo_full && !hit_ready;

  hit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (NONCE_W)
  ) u_hit_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (drain_push),
    .din   (drain_nonce),
    .pop   (hit_ready),
    .dout  (hit_nonce),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign hit_valid = !fifo_empty;

endmodule
